// File: rtl/ped_crossing_if.sv
// ped_crossing_if: pedestrian endpoint signals between the road/button side and the crossing unit
interface ped_crossing_if;
  logic       button_raw;
  logic       road_red;
  logic       ped_request;
  logic       walk_lamp;
  logic       dont_walk_lamp;
  logic [6:0] walk_remaining;
  logic [2:0] ped_state;
  logic [7:0] wait_cycles;
  logic       abort_pulse;
  modport master (
    output button_raw, road_red,
    input  ped_request, walk_lamp, dont_walk_lamp, walk_remaining, ped_state, wait_cycles, abort_pulse
  );
  modport slave (
    input  button_raw, road_red,
    output ped_request, walk_lamp, dont_walk_lamp, walk_remaining, ped_state, wait_cycles, abort_pulse
  );
endinterface

// File: rtl/ped_crossing_unit.sv
// ped_crossing_unit: debounced pedestrian request plus WALK / flashing DON'T WALK sequencing for one road
module ped_crossing_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned WALK_TIME       = 20,
  parameter int unsigned CLEAR_TIME      = 10,
  parameter int unsigned LOCKOUT_TIME    = 5
) (
  input logic             clk,
  input logic             rst_n,
  ped_crossing_if.slave   bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQUESTED = 3'd1,
    WALK      = 3'd2,
    CLEARANCE = 3'd3,
    LOCKOUT   = 3'd4
  } state_e;
  state_e     state_q, state_d;
  logic       s1_q, s2_q, db_q, db_prev_q, red_prev_q;
  logic [3:0] cnt_q;
  logic [6:0] timer_q, timer_d;
  logic [7:0] wait_q, wait_d;
  logic       pending_q, pending_d, flash_q, flash_d, abort_q, abort_d;
  logic       press, red_rise, abort;
  assign press    = db_q & ~db_prev_q;
  assign red_rise = bus.road_red & ~red_prev_q;
  assign abort    = (state_q == WALK || state_q == CLEARANCE) && !bus.road_red;
  // Synchronise the button, debounce its level and remember last-cycle values for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_q       <= 1'b0;
      db_prev_q  <= 1'b0;
      cnt_q      <= 4'd0;
      red_prev_q <= 1'b0;
    end else begin
      s1_q       <= bus.button_raw;
      s2_q       <= s1_q;
      db_prev_q  <= db_q;
      red_prev_q <= bus.road_red;
      if (s2_q == db_q) cnt_q <= 4'd0;
      else if (cnt_q == 4'(DEBOUNCE_CYCLES - 1)) begin
        db_q  <= s2_q;
        cnt_q <= 4'd0;
      end else cnt_q <= cnt_q + 4'd1;
    end
  end
  // Crossing state, phase timer, wait counter and pending-press bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= 7'd0;
      wait_q    <= 8'd0;
      pending_q <= 1'b0;
      flash_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      flash_q   <= flash_d;
      abort_q   <= abort_d;
    end
  end
  // Next-state logic; a red drop during WALK/CLEARANCE overrides everything and returns to IDLE
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    wait_d    = wait_q;
    pending_d = pending_q;
    flash_d   = flash_q;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = REQUESTED;
          wait_d  = 8'd0;
        end
      end
      REQUESTED: begin
        wait_d = (wait_q == 8'hff) ? wait_q : wait_q + 8'd1;
        if (red_rise) begin
          state_d = WALK;
          timer_d = 7'(WALK_TIME);
        end
      end
      WALK: begin
        timer_d = timer_q - 7'd1;
        if (timer_q == 7'd1) begin
          state_d = CLEARANCE;
          timer_d = 7'(CLEAR_TIME);
          flash_d = 1'b1;
        end
      end
      CLEARANCE: begin
        flash_d   = ~flash_q;
        pending_d = pending_q | press;
        timer_d   = timer_q - 7'd1;
        if (timer_q == 7'd1) begin
          state_d = LOCKOUT;
          timer_d = 7'(LOCKOUT_TIME);
        end
      end
      LOCKOUT: begin
        pending_d = pending_q | press;
        timer_d   = timer_q - 7'd1;
        if (timer_q == 7'd1) begin
          state_d   = (pending_q | press) ? REQUESTED : IDLE;
          wait_d    = (pending_q | press) ? 8'd0 : wait_q;
          pending_d = 1'b0;
          timer_d   = 7'd0;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = 7'd0;
        pending_d = 1'b0;
      end
    endcase
    if (abort) begin
      state_d   = IDLE;
      timer_d   = 7'd0;
      pending_d = 1'b0;
      abort_d   = 1'b1;
    end
  end
  assign bus.ped_request    = state_q == REQUESTED;
  assign bus.walk_lamp      = state_q == WALK;
  assign bus.dont_walk_lamp = (state_q == CLEARANCE) ? flash_q : state_q != WALK;
  assign bus.walk_remaining = timer_q;
  assign bus.ped_state      = state_q;
  assign bus.wait_cycles    = wait_q;
  assign bus.abort_pulse    = abort_q;
endmodule
